// File: rtl/sort_scheduler.sv
// Round-robin arbiter sharing one top-K minimum sorter among REQ_NUM frame buffers.
// Grants a requester, starts the sorter, captures its results, and returns them tagged with the owner.
module sort_scheduler #(
    parameter int REQ_NUM     = 4,
    parameter int REQ_WIDTH   = 2,
    parameter int OUT_NUM     = 4,
    parameter int DATA_LENGTH = 14,
    parameter int NUM_WIDTH   = 6,
    parameter int TIMEOUT     = 63,
    parameter int TO_WIDTH    = 7
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [REQ_NUM-1:0]             req,
    output logic [REQ_NUM-1:0]             req_ack,
    output logic [REQ_WIDTH-1:0]           sel,
    output logic                           sort_start,
    input  logic                           sort_finish,
    input  logic [OUT_NUM*DATA_LENGTH-1:0] sorted_data,
    input  logic [OUT_NUM*NUM_WIDTH-1:0]   sorted_addr,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [REQ_WIDTH-1:0]           resp_id,
    output logic [OUT_NUM*DATA_LENGTH-1:0] resp_data,
    output logic [OUT_NUM*NUM_WIDTH-1:0]   resp_addr,
    output logic                           resp_timeout,
    output logic                           busy
);

    // state | meaning
    // IDLE  | waiting for any req; arbitrates from rr_ptr
    // START | one-cycle sorter start pulse, watchdog cleared
    // RUN   | waiting for sort_finish or watchdog expiry
    // RESP  | holding the response until resp_ready
    typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;

    state_t               state;
    logic [REQ_WIDTH-1:0] rr_ptr;
    logic [REQ_WIDTH-1:0] grant_idx;
    logic [REQ_WIDTH-1:0] cand;
    logic                 grant_vld;
    logic [TO_WIDTH-1:0]  wdog;

    // Descending scan so the lowest offset from rr_ptr is the final winner.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr;
        cand      = rr_ptr;
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            cand = rr_ptr + REQ_WIDTH'(i);
            if (req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign sort_start = (state == START);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            sel          <= '0;
            resp_id      <= '0;
            resp_valid   <= 1'b0;
            resp_timeout <= 1'b0;
            req_ack      <= '0;
            resp_data    <= '1;
            resp_addr    <= '1;
            wdog         <= '0;
        end else begin
            req_ack <= '0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        sel     <= grant_idx;
                        resp_id <= grant_idx;
                        state   <= START;
                    end
                end
                START: begin
                    wdog  <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (wdog != TO_WIDTH'(TIMEOUT - 1))
                        wdog <= wdog + 1'b1;
                    // Sorter outputs are only valid during the finish pulse, so capture now.
                    if (sort_finish) begin
                        resp_data    <= sorted_data;
                        resp_addr    <= sorted_addr;
                        resp_timeout <= 1'b0;
                        resp_valid   <= 1'b1;
                        state        <= RESP;
                    end else if (wdog == TO_WIDTH'(TIMEOUT - 1)) begin
                        resp_data    <= '1;
                        resp_addr    <= '1;
                        resp_timeout <= 1'b1;
                        resp_valid   <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ack    <= REQ_NUM'(1) << resp_id;
                        rr_ptr     <= resp_id + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
